// File: rtl/riscv_pkg.sv
// +----------------------------------------------------------------------+
// | riscv_pkg: result-source encoding and load funct3 constants shared   |
// | by the control unit and the writeback stage.   Rev 1.0               |
// +----------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } res_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// +----------------------------------------------------------------------+
// | load_extend: selects byte/halfword from an aligned word and sign- or |
// | zero-extends it to the datapath width.          Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module load_extend
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [1:0]            offset_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = word_i[{offset_i, 3'b000} +: 8];
    // Halfword loads assume alignment was enforced upstream; offset[0] is ignored.
    half_w = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(DATA_WIDTH-8){byte_w[7]}}, byte_w};
      F3_LH:   data_o = {{(DATA_WIDTH-16){half_w[15]}}, half_w};
      F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_w};
      F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_w};
      default: data_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback.sv
// +----------------------------------------------------------------------+
// | writeback: MEM/WB register, result select, regfile write drive and   |
// | retired-instruction counter.                    Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module writeback
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallW_i,
  input  logic                  FlushW_i,
  input  logic                  ValidM_i,
  input  logic                  RegWriteM_i,
  input  logic [1:0]            ResultSrcM_i,
  input  logic [2:0]            Funct3M_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0] ReadDataM_i,
  input  logic [DATA_WIDTH-1:0] PC_Plus4M_i,
  input  logic [DATA_WIDTH-1:0] ImmExtM_i,
  input  logic [4:0]            RdM_i,
  output logic [4:0]            RdW_o,
  output logic [DATA_WIDTH-1:0] ResultW_o,
  output logic                  RegWriteW_o,
  output logic                  ValidW_o,
  output logic [CNT_WIDTH-1:0]  InstRet_o
);

  logic                  Valid_q,     Valid_d;
  logic                  RegWrite_q,  RegWrite_d;
  res_src_e              ResultSrc_q, ResultSrc_d;
  logic [2:0]            Funct3_q,    Funct3_d;
  logic [DATA_WIDTH-1:0] ALUResult_q, ALUResult_d;
  logic [DATA_WIDTH-1:0] ReadData_q,  ReadData_d;
  logic [DATA_WIDTH-1:0] PC_Plus4_q,  PC_Plus4_d;
  logic [DATA_WIDTH-1:0] ImmExt_q,    ImmExt_d;
  logic [4:0]            Rd_q,        Rd_d;
  logic [CNT_WIDTH-1:0]  InstRet_q,   InstRet_d;

  logic                  retire_w;
  logic [DATA_WIDTH-1:0] load_w;

  // An instruction retires when it leaves W: either replaced (no stall) or squashed by flush.
  assign retire_w = Valid_q & (~StallW_i | FlushW_i);

  always_comb begin
    Valid_d     = Valid_q;
    RegWrite_d  = RegWrite_q;
    ResultSrc_d = ResultSrc_q;
    Funct3_d    = Funct3_q;
    ALUResult_d = ALUResult_q;
    ReadData_d  = ReadData_q;
    PC_Plus4_d  = PC_Plus4_q;
    ImmExt_d    = ImmExt_q;
    Rd_d        = Rd_q;
    InstRet_d   = InstRet_q + {{(CNT_WIDTH-1){1'b0}}, retire_w};
    if (FlushW_i) begin
      Valid_d     = 1'b0;
      RegWrite_d  = 1'b0;
      ResultSrc_d = RES_ALU;
      Funct3_d    = '0;
      ALUResult_d = '0;
      ReadData_d  = '0;
      PC_Plus4_d  = '0;
      ImmExt_d    = '0;
      Rd_d        = '0;
    end else if (!StallW_i) begin
      Valid_d     = ValidM_i;
      RegWrite_d  = RegWriteM_i;
      ResultSrc_d = res_src_e'(ResultSrcM_i);
      Funct3_d    = Funct3M_i;
      ALUResult_d = ALUResultM_i;
      ReadData_d  = ReadDataM_i;
      PC_Plus4_d  = PC_Plus4M_i;
      ImmExt_d    = ImmExtM_i;
      Rd_d        = RdM_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Valid_q     <= 1'b0;
      RegWrite_q  <= 1'b0;
      ResultSrc_q <= RES_ALU;
      Funct3_q    <= '0;
      ALUResult_q <= '0;
      ReadData_q  <= '0;
      PC_Plus4_q  <= '0;
      ImmExt_q    <= '0;
      Rd_q        <= '0;
      InstRet_q   <= '0;
    end else begin
      Valid_q     <= Valid_d;
      RegWrite_q  <= RegWrite_d;
      ResultSrc_q <= ResultSrc_d;
      Funct3_q    <= Funct3_d;
      ALUResult_q <= ALUResult_d;
      ReadData_q  <= ReadData_d;
      PC_Plus4_q  <= PC_Plus4_d;
      ImmExt_q    <= ImmExt_d;
      Rd_q        <= Rd_d;
      InstRet_q   <= InstRet_d;
    end
  end

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .word_i   (ReadData_q),
    .offset_i (ALUResult_q[1:0]),
    .funct3_i (Funct3_q),
    .data_o   (load_w)
  );

  always_comb begin
    ResultW_o = ALUResult_q;
    unique case (ResultSrc_q)
      RES_ALU:  ResultW_o = ALUResult_q;
      RES_LOAD: ResultW_o = load_w;
      RES_PC4:  ResultW_o = PC_Plus4_q;
      RES_IMM:  ResultW_o = ImmExt_q;
    endcase
  end

  assign RdW_o       = Rd_q;
  assign ValidW_o    = Valid_q;
  assign RegWriteW_o = RegWrite_q & Valid_q & (Rd_q != 5'd0);
  assign InstRet_o   = InstRet_q;

endmodule

`default_nettype wire
